// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if -- handshake/control bundle between the instruction
// sequencer and the rest of the multicycle datapath.
//   opcode    [5:0]  instruction[31:26] from the instruction register
//   mem_ready        memory access completes this cycle
//   ctrl      [15:0] bundled datapath controls (see multicycle_ctrl)
//   link             JAL writeback select ($31 / PC)
//   state     [3:0]  current sequencer state, for debug
//   err              sticky fault flag
// master: the datapath/memory side (drives opcode, mem_ready)
// slave : the sequencer (drives ctrl, link, state, err)
interface multicycle_ctrl_if;
    logic [5:0]  opcode;
    logic        mem_ready;
    logic [15:0] ctrl;
    logic        link;
    logic [3:0]  state;
    logic        err;

    modport master (output opcode, mem_ready, input ctrl, link, state, err);
    modport slave  (input opcode, mem_ready, output ctrl, link, state, err);
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl -- Moore sequencer for a MIPS-style multicycle datapath.
// Walks FETCH/DECODE and the per-class execute states, producing the
// datapath control bundle, with a bounded wait on every memory state.
//
// Ports:
//   clk  sole clock, rising edge
//   rst  synchronous active-high reset
//   bus  multicycle_ctrl_if.slave (opcode, mem_ready in; ctrl, link, state, err out)
//
// Parameter:
//   MEM_TIMEOUT  wait cycles a memory state tolerates before entering ERR
//
// Build option:
//   MULTICYCLE_CTRL_JAL_EN  when defined, opcode 000011 executes JAL;
//                           otherwise it is an illegal opcode and link is 0.
//
// ctrl bit map:
//   [0] pc_write  [1] pc_write_cond  [2] iord      [3] mem_read
//   [4] mem_write [5] ir_write       [6] mem_to_reg [7] reg_dst
//   [8] reg_write [9] alu_src_a      [11:10] alu_src_b
//   [13:12] alu_op [15:14] pc_src
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    multicycle_ctrl_if.slave  bus
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11,
        S_JAL    = 4'd12,
        S_ERR    = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    // ctrl field positions
    localparam int PC_WRITE      = 0;
    localparam int PC_WRITE_COND = 1;
    localparam int IORD          = 2;
    localparam int MEM_READ      = 3;
    localparam int MEM_WRITE     = 4;
    localparam int IR_WRITE      = 5;
    localparam int MEM_TO_REG    = 6;
    localparam int REG_DST       = 7;
    localparam int REG_WRITE     = 8;
    localparam int ALU_SRC_A     = 9;
    localparam int ALU_SRC_B     = 10;  // 2 bits
    localparam int ALU_OP        = 12;  // 2 bits
    localparam int PC_SRC        = 14;  // 2 bits

    // FETCH strobes that only fire on the cycle the instruction arrives
    localparam logic [15:0] FETCH_STROBES =
        (16'd1 << PC_WRITE) | (16'd1 << IR_WRITE);

    localparam int CW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

    state_t        cur;
    state_t        nxt;
    logic [CW-1:0] wait_cnt;
    logic [5:0]    op_q;
    logic [15:0]   ctrl_q;
    logic          err_q;
    logic          timeout;
    logic          fetch_strobe;

    // Moore part of ctrl. The FETCH pc_write/ir_write strobes are added
    // outside because they follow mem_ready within the cycle.
    function automatic logic [15:0] moore_ctrl(input state_t s);
        logic [15:0] c;
        c = '0;
        case (s)
            S_FETCH: begin
                c[MEM_READ]         = 1'b1;
                c[ALU_SRC_B +: 2]   = 2'b01;
            end
            S_DECODE: c[ALU_SRC_B +: 2] = 2'b11;
            S_MEMADR: begin
                c[ALU_SRC_A]        = 1'b1;
                c[ALU_SRC_B +: 2]   = 2'b10;
            end
            S_MEMRD: begin
                c[MEM_READ]         = 1'b1;
                c[IORD]             = 1'b1;
            end
            S_MEMWB: begin
                c[REG_WRITE]        = 1'b1;
                c[MEM_TO_REG]       = 1'b1;
            end
            S_MEMWR: begin
                c[MEM_WRITE]        = 1'b1;
                c[IORD]             = 1'b1;
            end
            S_EXEC: begin
                c[ALU_SRC_A]        = 1'b1;
                c[ALU_OP +: 2]      = 2'b10;
            end
            S_ALUWB: begin
                c[REG_DST]          = 1'b1;
                c[REG_WRITE]        = 1'b1;
            end
            S_BRANCH: begin
                c[ALU_SRC_A]        = 1'b1;
                c[ALU_OP +: 2]      = 2'b01;
                c[PC_WRITE_COND]    = 1'b1;
                c[PC_SRC +: 2]      = 2'b01;
            end
            S_ADDIEX: begin
                c[ALU_SRC_A]        = 1'b1;
                c[ALU_SRC_B +: 2]   = 2'b10;
            end
            S_ADDIWB: c[REG_WRITE] = 1'b1;
            S_JUMP: begin
                c[PC_WRITE]         = 1'b1;
                c[PC_SRC +: 2]      = 2'b10;
            end
`ifdef MULTICYCLE_CTRL_JAL_EN
            S_JAL: begin
                c[PC_WRITE]         = 1'b1;
                c[PC_SRC +: 2]      = 2'b10;
                c[REG_WRITE]        = 1'b1;
            end
`endif
            default: c = '0;
        endcase
        return c;
    endfunction

    // Memory wait budget exhausted this cycle; a completing handshake
    // in the same cycle still wins because mem_ready is checked first.
    assign timeout = !bus.mem_ready && (wait_cnt >= CW'(MEM_TIMEOUT - 1));

    always_comb begin
        nxt = S_ERR;
        case (cur)
            S_FETCH:  nxt = bus.mem_ready ? S_DECODE : (timeout ? S_ERR : S_FETCH);
            S_DECODE: begin
                case (bus.opcode)
                    OP_RTYPE:      nxt = S_EXEC;
                    OP_LW, OP_SW:  nxt = S_MEMADR;
                    OP_BEQ:        nxt = S_BRANCH;
                    OP_ADDI:       nxt = S_ADDIEX;
                    OP_J:          nxt = S_JUMP;
`ifdef MULTICYCLE_CTRL_JAL_EN
                    OP_JAL:        nxt = S_JAL;
`endif
                    default:       nxt = S_ERR;
                endcase
            end
            // Only lw/sw reach MEMADR, so the latched opcode picks the path.
            S_MEMADR: nxt = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  nxt = bus.mem_ready ? S_MEMWB : (timeout ? S_ERR : S_MEMRD);
            S_MEMWR:  nxt = bus.mem_ready ? S_FETCH : (timeout ? S_ERR : S_MEMWR);
            S_EXEC:   nxt = S_ALUWB;
            S_ADDIEX: nxt = S_ADDIWB;
            S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: nxt = S_FETCH;
`ifdef MULTICYCLE_CTRL_JAL_EN
            S_JAL:    nxt = S_FETCH;
`endif
            S_ERR:    nxt = S_ERR;
            default:  nxt = S_ERR;   // 14/15 and, without JAL, 12
        endcase
    end

`ifdef MULTICYCLE_CTRL_JAL_EN
    logic link_q;
`endif

    // Sequencer state plus registered Moore outputs for the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur      <= S_FETCH;
            wait_cnt <= '0;
            op_q     <= '0;
            ctrl_q   <= moore_ctrl(S_FETCH);
            err_q    <= 1'b0;
`ifdef MULTICYCLE_CTRL_JAL_EN
            link_q   <= 1'b0;
`endif
        end else begin
            cur    <= nxt;
            ctrl_q <= moore_ctrl(nxt);
            err_q  <= (nxt == S_ERR);
`ifdef MULTICYCLE_CTRL_JAL_EN
            link_q <= (nxt == S_JAL);
`endif
            if (cur == S_DECODE)
                op_q <= bus.opcode;

            // Fresh budget on entry to any memory state; the FETCH
            // self-loop keeps counting.
            if ((nxt == S_FETCH || nxt == S_MEMRD || nxt == S_MEMWR) && nxt != cur)
                wait_cnt <= '0;
            else if ((cur == S_FETCH || cur == S_MEMRD || cur == S_MEMWR) && !bus.mem_ready)
                wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign fetch_strobe = (cur == S_FETCH) && bus.mem_ready;

    // Reset masks every strobe so an abandoned instruction writes nothing.
    assign bus.ctrl  = rst ? 16'd0 : (ctrl_q | (fetch_strobe ? FETCH_STROBES : 16'd0));
    assign bus.err   = err_q & ~rst;
    assign bus.state = cur;
`ifdef MULTICYCLE_CTRL_JAL_EN
    assign bus.link  = link_q & ~rst;
`else
    assign bus.link  = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl -- directed vector table plus hand-written sequences
// for reset-abandon, memory timeout and timeout/completion race.
module tb_multicycle_ctrl;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    // hand-computed ctrl words
    localparam logic [15:0] C_FETCH_RDY = 16'h0429;
    localparam logic [15:0] C_FETCH_WT  = 16'h0408;
    localparam logic [15:0] C_DECODE    = 16'h0C00;
    localparam logic [15:0] C_MEMADR    = 16'h0A00;
    localparam logic [15:0] C_MEMRD     = 16'h000C;
    localparam logic [15:0] C_MEMWB     = 16'h0140;
    localparam logic [15:0] C_MEMWR     = 16'h0014;
    localparam logic [15:0] C_EXEC      = 16'h2200;
    localparam logic [15:0] C_ALUWB     = 16'h0180;
    localparam logic [15:0] C_BRANCH    = 16'h5202;
    localparam logic [15:0] C_ADDIEX    = 16'h0A00;
    localparam logic [15:0] C_ADDIWB    = 16'h0100;
    localparam logic [15:0] C_JUMP      = 16'h8001;
    localparam logic [15:0] C_JAL       = 16'h8101;

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic        mr;
        logic [3:0]  st;
        logic [15:0] ctrl;
        logic        link;
        logic        err;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    vec_t vq[$];

    multicycle_ctrl_if bus ();

    multicycle_ctrl #(.MEM_TIMEOUT(15)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        bus.opcode    = 6'd0;
        bus.mem_ready = 1'b1;
    end

    task automatic add(input logic r, input logic [5:0] op, input logic mr,
                       input logic [3:0] st, input logic [15:0] c,
                       input logic l, input logic e);
        vec_t v;
        v.rst = r; v.op = op; v.mr = mr; v.st = st; v.ctrl = c; v.link = l; v.err = e;
        vq.push_back(v);
    endtask

    // One cycle: drive after the falling edge, settle, then the caller checks.
    task automatic cyc(input logic r, input logic [5:0] op, input logic mr);
        @(negedge clk);
        rst           = r;
        bus.opcode    = op;
        bus.mem_ready = mr;
        #1;
    endtask

    task automatic check(input string name, input logic [3:0] st, input logic [15:0] c,
                         input logic l, input logic e);
        checks++;
        if (bus.state !== st || bus.ctrl !== c || bus.link !== l || bus.err !== e) begin
            errors++;
            $display("FAIL %s: got state=%0d ctrl=%h link=%b err=%b, want state=%0d ctrl=%h link=%b err=%b",
                     name, bus.state, bus.ctrl, bus.link, bus.err, st, c, l, e);
        end
    endtask

    initial begin
        // reset, then lw with zero-wait memory
        add(1, OP_R,   1, 0, 16'h0, 0, 0);
        add(1, OP_R,   1, 0, 16'h0, 0, 0);
        add(0, OP_R,   1, 0, C_FETCH_RDY, 0, 0);
        add(0, OP_LW,  1, 1, C_DECODE, 0, 0);
        add(0, OP_R,   1, 2, C_MEMADR, 0, 0);   // opcode changed: latch must hold lw
        add(0, OP_R,   1, 3, C_MEMRD, 0, 0);
        add(0, OP_R,   1, 4, C_MEMWB, 0, 0);
        add(0, OP_R,   1, 0, C_FETCH_RDY, 0, 0);
        // sw with three wait cycles in MEMWR
        add(0, OP_SW,  1, 1, C_DECODE, 0, 0);
        add(0, OP_R,   1, 2, C_MEMADR, 0, 0);
        add(0, OP_R,   0, 5, C_MEMWR, 0, 0);
        add(0, OP_R,   0, 5, C_MEMWR, 0, 0);
        add(0, OP_R,   0, 5, C_MEMWR, 0, 0);
        add(0, OP_R,   1, 5, C_MEMWR, 0, 0);
        add(0, OP_R,   1, 0, C_FETCH_RDY, 0, 0);
        // R-type
        add(0, OP_R,   1, 1, C_DECODE, 0, 0);
        add(0, OP_R,   1, 6, C_EXEC, 0, 0);
        add(0, OP_R,   1, 7, C_ALUWB, 0, 0);
        add(0, OP_R,   1, 0, C_FETCH_RDY, 0, 0);
        // beq
        add(0, OP_BEQ, 1, 1, C_DECODE, 0, 0);
        add(0, OP_R,   1, 8, C_BRANCH, 0, 0);
        add(0, OP_R,   1, 0, C_FETCH_RDY, 0, 0);
        // addi
        add(0, OP_ADDI,1, 1, C_DECODE, 0, 0);
        add(0, OP_R,   1, 9, C_ADDIEX, 0, 0);
        add(0, OP_R,   1, 10, C_ADDIWB, 0, 0);
        add(0, OP_R,   1, 0, C_FETCH_RDY, 0, 0);
        // j, then a FETCH wait cycle (strobes gated off)
        add(0, OP_J,   1, 1, C_DECODE, 0, 0);
        add(0, OP_R,   1, 11, C_JUMP, 0, 0);
        add(0, OP_R,   0, 0, C_FETCH_WT, 0, 0);
        add(0, OP_R,   1, 0, C_FETCH_RDY, 0, 0);
        // jal
        add(0, OP_JAL, 1, 1, C_DECODE, 0, 0);
`ifdef MULTICYCLE_CTRL_JAL_EN
        add(0, OP_R,   1, 12, C_JAL, 1, 0);
        add(0, OP_R,   1, 0, C_FETCH_RDY, 0, 0);
`else
        add(0, OP_R,   1, 13, 16'h0, 0, 1);
        add(1, OP_R,   1, 13, 16'h0, 0, 0);   // reset masks err
        add(0, OP_R,   1, 0, C_FETCH_RDY, 0, 0);
`endif
        // illegal opcode goes straight to ERR and stays
        add(0, OP_BAD, 1, 1, C_DECODE, 0, 0);
        add(0, OP_R,   1, 13, 16'h0, 0, 1);
        add(0, OP_R,   1, 13, 16'h0, 0, 1);

        for (int i = 0; i < vq.size(); i++) begin
            cyc(vq[i].rst, vq[i].op, vq[i].mr);
            check($sformatf("vec%0d", i), vq[i].st, vq[i].ctrl, vq[i].link, vq[i].err);
        end

        // reset during MEMRD abandons the load without write strobes
        cyc(1, OP_R, 1);
        cyc(0, OP_R, 1);
        cyc(0, OP_LW, 1);
        cyc(0, OP_R, 1);
        cyc(0, OP_R, 0);
        check("rst_memrd_pre", 3, C_MEMRD, 0, 0);
        cyc(1, OP_R, 1);
        check("rst_memrd_cycle", 3, 16'h0, 0, 0);
        cyc(0, OP_R, 0);
        check("rst_memrd_after", 0, C_FETCH_WT, 0, 0);

        // FETCH timeout: ERR after the 15th wait cycle, sticky until rst
        cyc(1, OP_R, 0);
        for (int k = 1; k <= 15; k++) begin
            cyc(0, OP_R, 0);
            if (k == 1 || k == 15)
                check($sformatf("tmo_wait%0d", k), 0, C_FETCH_WT, 0, 0);
        end
        cyc(0, OP_R, 0);
        check("tmo_err", 13, 16'h0, 0, 1);
        for (int k = 0; k < 3; k++) cyc(0, OP_R, 1);
        check("tmo_sticky", 13, 16'h0, 0, 1);
        cyc(1, OP_R, 1);
        check("tmo_rst_cycle", 13, 16'h0, 0, 0);
        cyc(0, OP_R, 1);
        check("tmo_rst_after", 0, C_FETCH_RDY, 0, 0);

        // completion on the last allowed cycle beats the timeout
        cyc(1, OP_R, 0);
        for (int k = 1; k <= 14; k++) cyc(0, OP_R, 0);
        cyc(0, OP_R, 1);
        check("race_fetch", 0, C_FETCH_RDY, 0, 0);
        cyc(0, OP_ADDI, 1);
        check("race_decode", 1, C_DECODE, 0, 0);

        // MEMWR gets a fresh budget after a waited FETCH, then times out
        cyc(1, OP_R, 0);
        for (int k = 0; k < 5; k++) cyc(0, OP_R, 0);
        cyc(0, OP_R, 1);
        cyc(0, OP_SW, 0);
        cyc(0, OP_R, 0);
        for (int k = 1; k <= 15; k++) begin
            cyc(0, OP_R, 0);
            if (k == 15)
                check("memwr_wait15", 5, C_MEMWR, 0, 0);
        end
        cyc(0, OP_R, 0);
        check("memwr_tmo_err", 13, 16'h0, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
